// File: rtl/switch_toggle_decoder_if.sv
// Game-side handshake between switch_toggle_decoder and the game FSM.
//   slave  : decoder side (takes arm/disarm/target, drives status and pulses)
//   master : game FSM side
interface switch_toggle_decoder_if #(
    parameter int NUM_SW = 18
);
    localparam int IDX_W = $clog2(NUM_SW);

    logic             arm;
    logic             disarm;
    logic             target_valid;
    logic [IDX_W-1:0] target_index;
    logic             ready;
    logic             armed;
    logic             hit;
    logic             miss;
    logic             multi_toggle;
    logic [IDX_W-1:0] toggle_index;

    modport slave (
        input  arm, disarm, target_valid, target_index,
        output ready, armed, hit, miss, multi_toggle, toggle_index
    );

    modport master (
        output arm, disarm, target_valid, target_index,
        input  ready, armed, hit, miss, multi_toggle, toggle_index
    );
endinterface

// File: rtl/switch_toggle_decoder.sv
// switch_toggle_decoder: decodes the player's answer from the 18 slide switches.
// It synchronises and debounces the raw switch vector. On arm it captures a
// baseline. The first settled change from that baseline is then reported as a
// one-cycle hit or miss.
// Ports:
//   clk, reset_n  - system clock, async active-low reset
//   switches      - raw asynchronous switch levels
//   debounced_sw  - current debounced switch vector
//   bus (slave)   - arm/disarm/target in; ready/armed/hit/miss/multi_toggle/toggle_index out
//
// state  | meaning
// IDLE   | not watching; waits for arm while ready
// ARMED  | baseline held, watching for a settled change
// REPORT | one cycle: hit/miss/multi_toggle valid
module switch_toggle_decoder #(
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_SW-1:0]     switches,
    output logic [NUM_SW-1:0]     debounced_sw,
    switch_toggle_decoder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SW);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_SW-1:0] ONE     = NUM_SW'(1);

    typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

    state_t             state, state_nxt;
    logic [NUM_SW-1:0]  sync1, sync2, sync_prev;
    logic [CNT_W-1:0]   stable_cnt;
    logic [NUM_SW-1:0]  baseline, baseline_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               hit_nxt, miss_nxt, multi_nxt;
    logic [NUM_SW-1:0]  diff;
    logic [IDX_W-1:0]   low_idx;
    logic               multiple;
    logic               stable;

    // sync_prev holds sync2 one cycle back so a change restarts the window.
    assign stable = (sync2 == sync_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            sync_prev    <= '0;
            stable_cnt   <= '0;
            debounced_sw <= '0;
            bus.ready    <= 1'b0;
        end else begin
            sync1     <= switches;
            sync2     <= sync1;
            sync_prev <= sync2;
            if (!stable) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            // Saturated counter keeps reloading; the stable guard stops a
            // fresh change from slipping through on its first cycle.
            if (stable && stable_cnt == CNT_MAX) begin
                debounced_sw <= sync2;
                bus.ready    <= 1'b1;
            end
        end
    end

    assign diff     = debounced_sw ^ baseline;
    assign multiple = |(diff & (diff - ONE));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (diff[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            baseline         <= '0;
            bus.toggle_index <= '0;
            bus.hit          <= 1'b0;
            bus.miss         <= 1'b0;
            bus.multi_toggle <= 1'b0;
        end else begin
            state            <= state_nxt;
            baseline         <= baseline_nxt;
            bus.toggle_index <= idx_nxt;
            bus.hit          <= hit_nxt;
            bus.miss         <= miss_nxt;
            bus.multi_toggle <= multi_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baseline_nxt = baseline;
        idx_nxt      = bus.toggle_index;
        hit_nxt      = 1'b0;
        miss_nxt     = 1'b0;
        multi_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.arm && bus.ready) begin
                    baseline_nxt = debounced_sw;
                    idx_nxt      = '0;
                    state_nxt    = ARMED;
                end
            end
            ARMED: begin
                if (bus.disarm) begin
                    state_nxt = IDLE;
                end else if (bus.arm) begin
                    baseline_nxt = debounced_sw;
                end else if (diff != '0) begin
                    hit_nxt   = !multiple && bus.target_valid && (low_idx == bus.target_index);
                    miss_nxt  = !hit_nxt;
                    multi_nxt = multiple;
                    idx_nxt   = low_idx;
                    state_nxt = REPORT;
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.armed = (state == ARMED);
endmodule

// File: tb/tb_switch_toggle_decoder.sv
module tb_switch_toggle_decoder;
    localparam int NUM_SW = 18;
    localparam int IDX_W  = $clog2(NUM_SW);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_SW-1:0] switches;
    logic [NUM_SW-1:0] debounced_sw;
    int                checks = 0;
    int                failures = 0;
    bit                got;

    switch_toggle_decoder_if #(.NUM_SW(NUM_SW)) bus ();

    switch_toggle_decoder #(.NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .switches     (switches),
        .debounced_sw (debounced_sw),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a hit or miss pulse.
    task automatic wait_pulse(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.hit || bus.miss) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        switches         = 18'h00005;
        bus.arm          = 1'b0;
        bus.disarm       = 1'b0;
        bus.target_valid = 1'b0;
        bus.target_index = '0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_armed", 32'(bus.armed), 32'd0);
        chk("rst_hit",   32'(bus.hit), 32'd0);
        chk("rst_miss",  32'(bus.miss), 32'd0);
        chk("rst_deb",   32'(debounced_sw), 32'd0);
        reset_n = 1'b1;

        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("ready_low_window", 32'(bus.ready), 32'd0);
        end
        tick();
        chk("ready_set", 32'(bus.ready), 32'd1);
        chk("deb_init", 32'(debounced_sw), 32'h00005);

        // hit with exact latency
        bus.target_valid = 1'b1;
        bus.target_index = IDX_W'(7);
        do_arm();
        chk("armed_after_arm", 32'(bus.armed), 32'd1);
        switches = 18'h00085;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("no_early_hit", 32'(bus.hit | bus.miss), 32'd0);
        end
        chk("deb_latency", 32'(debounced_sw), 32'h00085);
        tick();
        chk("hit_pulse", 32'(bus.hit), 32'd1);
        chk("hit_nomiss", 32'(bus.miss), 32'd0);
        chk("hit_idx", 32'(bus.toggle_index), 32'd7);
        tick();
        chk("hit_one_cycle", 32'(bus.hit), 32'd0);
        chk("idle_after_report", 32'(bus.armed), 32'd0);
        chk("idx_held", 32'(bus.toggle_index), 32'd7);

        // wrong switch
        do_arm();
        switches = 18'h0008D;
        wait_pulse(12, got);
        chk("miss_seen", 32'(got), 32'd1);
        chk("miss_pulse", 32'(bus.miss), 32'd1);
        chk("miss_nohit", 32'(bus.hit), 32'd0);
        chk("miss_idx", 32'(bus.toggle_index), 32'd3);
        chk("miss_multi", 32'(bus.multi_toggle), 32'd0);
        tick();

        // right switch but no target lit
        bus.target_valid = 1'b0;
        do_arm();
        switches = 18'h0000D;
        wait_pulse(12, got);
        chk("novalid_seen", 32'(got), 32'd1);
        chk("novalid_miss", 32'(bus.miss), 32'd1);
        chk("novalid_idx", 32'(bus.toggle_index), 32'd7);
        tick();

        // two switches at once
        bus.target_valid = 1'b1;
        bus.target_index = IDX_W'(2);
        do_arm();
        switches = 18'h00209;
        wait_pulse(12, got);
        chk("multi_seen", 32'(got), 32'd1);
        chk("multi_miss", 32'(bus.miss), 32'd1);
        chk("multi_nohit", 32'(bus.hit), 32'd0);
        chk("multi_flag", 32'(bus.multi_toggle), 32'd1);
        chk("multi_idx", 32'(bus.toggle_index), 32'd2);
        tick();

        // bounce shorter than the window
        do_arm();
        switches = 18'h00229;
        tick();
        tick();
        switches = 18'h00209;
        wait_pulse(15, got);
        chk("bounce_no_pulse", 32'(got), 32'd0);
        chk("bounce_armed", 32'(bus.armed), 32'd1);
        chk("bounce_deb", 32'(debounced_sw), 32'h00209);
        bus.disarm = 1'b1;
        tick();
        bus.disarm = 1'b0;
        chk("disarm", 32'(bus.armed), 32'd0);

        // disarm beats arm
        do_arm();
        bus.arm    = 1'b1;
        bus.disarm = 1'b1;
        tick();
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        chk("disarm_priority", 32'(bus.armed), 32'd0);
        switches = 18'h0020B;
        wait_pulse(15, got);
        chk("idle_no_pulse", 32'(got), 32'd0);
        chk("idle_deb", 32'(debounced_sw), 32'h0020B);

        // reset mid-debounce
        do_arm();
        switches = 18'h0021B;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_armed", 32'(bus.armed), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready), 32'd0);
        chk("mid_rst_pulse", 32'(bus.hit | bus.miss | bus.multi_toggle), 32'd0);
        chk("mid_rst_idx", 32'(bus.toggle_index), 32'd0);
        chk("mid_rst_deb", 32'(debounced_sw), 32'd0);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 2) bus.arm = 1'b1;
            tick();
            bus.arm = 1'b0;
            chk("rearm_ready_low", 32'(bus.ready), 32'd0);
            chk("arm_ignored_not_ready", 32'(bus.armed), 32'd0);
        end
        tick();
        chk("rearm_ready", 32'(bus.ready), 32'd1);
        chk("rearm_deb", 32'(debounced_sw), 32'h0021B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
